max_pool: RTL and testbench
===========================

MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 Parameter DW, default 20: pixel data width, signed two's complement.
REQ-002 Parameter IMG, default 64: input feature-map side, square; output side = IMG/2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ready  input  1  level request; start when high while busy low.
REQ-006 busy  output  1  high from acceptance until one cycle after the final write.
REQ-007 crd  output  1  read strobe toward layer memory.
REQ-008 caddr_rd  output  12  read address.
REQ-009 cdata_rd  input  DW  read data, valid at the rising edge after the crd cycle (1-cycle latency).
REQ-010 cwr  output  1  write strobe, sampled by memory on rising edge.
REQ-011 caddr_wr  output  12  write address.
REQ-012 cdata_wr  output  DW  write data.
REQ-013 csel  output  3  bank select: 3'b001 layer-0 source, 3'b011 layer-1 destination, 3'b000 idle.

Function
REQ-014 Computes 2x2 stride-2 max-pool of the 64x64 layer-0 map into the 32x32 layer-1 map; no rounding, no scaling.
REQ-015 FSM states: IDLE, RD0, RD1, RD2, RD3, WR, DONE.
REQ-016 IDLE->RD0 when ready=1; busy rises on that edge; row r and column c counters cleared to 0.
REQ-017 RDk (k=0..3): crd=1, csel=3'b001, caddr_rd={r[4:0], k[1], c[4:0], k[0]}, i.e. 128r+2c + {0,1,64,65}.
REQ-018 RD1/RD2/RD3/WR each capture cdata_rd from the previous read; RD1 loads the max register, later captures update it if signed cdata_rd > register.
REQ-019 WR: cwr=1, crd=0, csel=3'b011, caddr_wr={r,c}, cdata_wr=signed max(register, cdata_rd) combinationally.
REQ-020 Ties keep the earlier value (identical bits, so no observable difference).
REQ-021 After WR: c increments; c wrap 31->0 increments r; WR at r=31,c=31 -> DONE, else -> RD0.
REQ-022 Exactly 5 cycles per output; 5120 cycles from acceptance to last write.
REQ-023 DONE: busy=0, all strobes 0, csel=3'b000; -> IDLE next cycle; ready still high re-starts only from IDLE.
REQ-024 crd and cwr never high in the same cycle; csel=3'b000 whenever neither strobe is high.
REQ-025 ready transitions while busy=1 are ignored.
REQ-026 Addresses/data outputs hold 0 when not strobed.

Reset
REQ-027 reset=1 at a rising edge forces IDLE, r=c=0, max register 0, busy=0, crd=0, cwr=0, csel=3'b000, caddr_rd=0, caddr_wr=0, cdata_wr=0.
REQ-028 reset mid-operation aborts immediately; no further write issued; restart requires ready after reset release.
REQ-029 reset dominates ready in the same cycle.

Structure
REQ-030 Package max_pool_pkg holds: state enum, DW/IMG defaults, CSEL_L0=3'b001, CSEL_L1=3'b011, CSEL_NONE=3'b000.
REQ-031 One sub-module, max2_signed: combinational DW-bit signed two-input max, instantiated for both register update and cdata_wr.
REQ-032 Total RTL 120-400 lines; no memories inside the block.

Verification
REQ-033 Reset held 3 cycles, ready=1 -> busy rises next edge, first crd cycle addresses 0,1,64,65 in order, first write addr 0.
REQ-034 Layer-0 ramp L0[a]=a -> L1[{r,c}]=128r+2c+65 for all 1024 outputs; busy high 5121 cycles total.
REQ-035 Window values 0x00005,0xFFFFF(-1),0x00003,0x80000 at addr 0,1,64,65 -> write 0x00005 to addr 0 (signed compare).
REQ-036 All four window values equal 0x12345 -> writes 0x12345; max at index 3 only (0,0,0,0x00007) -> writes 0x00007.
REQ-037 reset asserted during 500th output's RD2 -> same edge outputs zero, no cwr thereafter, busy=0; rerun with ready produces full correct map.
REQ-038 Protocol assertions every cycle: !(crd&&cwr); csel==001 iff crd; csel==011 iff cwr; caddr_wr strictly increments 0..1023.

Source files
------------

// File: rtl/max_pool_pkg.sv
// rtl/max_pool_pkg.sv - shared states, defaults and bank-select codes for the max-pool block
package max_pool_pkg;

   localparam int DW_DEFAULT  = 20;
   localparam int IMG_DEFAULT = 64;
   localparam int ADDR_W      = 12;

   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;
   localparam logic [2:0] CSEL_NONE = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_RD3,
      ST_WR,
      ST_DONE
   } state_e;

endpackage

// File: rtl/max2_signed.sv
// rtl/max2_signed.sv - combinational signed two-input max; ties return a_i
module max2_signed
   import max_pool_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] y_o
);

   assign y_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;

endmodule

// File: rtl/max_pool.sv
// rtl/max_pool.sv - 2x2 stride-2 signed max-pool from layer-0 memory into layer-1 memory
module max_pool
   import max_pool_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int IMG = IMG_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   output logic              busy,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   input  logic [DW-1:0]     cdata_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [DW-1:0]     cdata_wr,
   output logic [2:0]        csel
);

   localparam int OW = $clog2(IMG / 2);
   localparam logic [OW-1:0] LAST = OW'(IMG / 2 - 1);

   state_e        state_q, state_d;
   logic [OW-1:0] r_q, r_d;
   logic [OW-1:0] c_q, c_d;
   logic [DW-1:0] max_q, max_d;
   logic [DW-1:0] pool_max;
   logic [1:0]    rd_k;

   // One comparator serves both the running-max update and the final write value.
   max2_signed #(.DW(DW)) u_max (
      .a_i (max_q),
      .b_i (cdata_rd),
      .y_o (pool_max)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         c_q     <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         max_q   <= max_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      c_d      = c_q;
      max_d    = max_q;
      busy     = 1'b0;
      crd      = 1'b0;
      cwr      = 1'b0;
      caddr_rd = '0;
      caddr_wr = '0;
      cdata_wr = '0;
      csel     = CSEL_NONE;
      rd_k     = 2'd0;

      case (state_q)
         ST_IDLE: begin
            if (ready) begin
               state_d = ST_RD0;
               r_d     = '0;
               c_d     = '0;
            end
         end
         ST_RD0: begin
            rd_k    = 2'd0;
            state_d = ST_RD1;
         end
         ST_RD1: begin
            rd_k    = 2'd1;
            max_d   = cdata_rd;
            state_d = ST_RD2;
         end
         ST_RD2: begin
            rd_k    = 2'd2;
            max_d   = pool_max;
            state_d = ST_RD3;
         end
         ST_RD3: begin
            rd_k    = 2'd3;
            max_d   = pool_max;
            state_d = ST_WR;
         end
         ST_WR: begin
            busy     = 1'b1;
            cwr      = 1'b1;
            csel     = CSEL_L1;
            caddr_wr = ADDR_W'({r_q, c_q});
            cdata_wr = pool_max;
            c_d      = (c_q == LAST) ? '0 : c_q + 1'b1;
            if (c_q == LAST) begin
               r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
            end
            state_d  = (r_q == LAST && c_q == LAST) ? ST_DONE : ST_RD0;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Window element k sits at row offset k[1] and column offset k[0].
      if (state_q inside {ST_RD0, ST_RD1, ST_RD2, ST_RD3}) begin
         busy     = 1'b1;
         crd      = 1'b1;
         csel     = CSEL_L0;
         caddr_rd = ADDR_W'({r_q, rd_k[1], c_q, rd_k[0]});
      end
   end

endmodule

// File: tb/tb_max_pool.sv
// tb/tb_max_pool.sv - self-checking bench for max_pool against a window-max reference model
module tb_max_pool;

   localparam int DW = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          ready;
   logic          busy;
   logic          crd;
   logic [11:0]   caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic          cwr;
   logic [11:0]   caddr_wr;
   logic [DW-1:0] cdata_wr;
   logic [2:0]    csel;

   logic [DW-1:0] l0    [0:4095];
   logic [DW-1:0] exp_q [0:1023];
   logic [DW-1:0] l1    [0:1023];

   int off [4] = '{0, 1, 64, 65};
   int checks = 0;
   int errors = 0;
   int rd_idx = 0;
   int wr_idx = 0;
   int edges  = 0;

   max_pool #(.DW(DW), .IMG(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .busy     (busy),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .csel     (csel)
   );

   always #5 clk = ~clk;

   // Layer-0 memory: one-cycle read latency, junk on the bus when not reading.
   always @(posedge clk) begin
      cdata_rd <= crd ? l0[caddr_rd] : DW'($urandom);
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic void build_model();
      for (int i = 0; i < 1024; i++) begin
         int base = 128 * (i / 32) + 2 * (i % 32);
         int m = 0;
         for (int k = 0; k < 4; k++) begin
            logic signed [DW-1:0] s;
            int v;
            s = l0[base + off[k]];
            v = s;
            if (k == 0 || v > m) m = v;
         end
         exp_q[i] = DW'(m);
      end
   endfunction

   always @(negedge clk) begin
      int o;
      chk("strobe_excl", longint'(crd && cwr), 0);
      chk("csel_iff_rd", longint'(csel == 3'b001), longint'(crd));
      chk("csel_iff_wr", longint'(csel == 3'b011), longint'(cwr));
      if (!crd) chk("rd_addr_idle", caddr_rd, 0);
      if (!cwr) begin
         chk("wr_addr_idle", caddr_wr, 0);
         chk("wr_data_idle", cdata_wr, 0);
      end
      if (crd) begin
         o = rd_idx / 4;
         chk("rd_addr", caddr_rd, 128 * (o / 32) + 2 * (o % 32) + off[rd_idx % 4]);
         rd_idx++;
      end
      if (cwr) begin
         if (wr_idx < 1024) begin
            chk("wr_addr", caddr_wr, wr_idx);
            chk("wr_data", cdata_wr, exp_q[wr_idx]);
            l1[wr_idx] = cdata_wr;
         end else begin
            chk("extra_write", wr_idx, 1023);
         end
         wr_idx++;
      end
   end

   task automatic step();
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (busy && guard < 6000) begin
         step();
         guard++;
      end
      chk("done_timeout", longint'(busy), 0);
   endtask

   task automatic fill_ramp();
      for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
      build_model();
   endtask

   initial begin
      int guard;
      int v [3];
      reset = 1'b1;
      ready = 1'b1;
      fill_ramp();
      chk("model_ramp_0", exp_q[0], 65);
      chk("model_ramp_33", exp_q[33], 195);
      chk("model_ramp_1023", exp_q[1023], 4095);

      // Reset dominates a held ready for three cycles.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_busy", longint'(busy), 0);
         chk("rst_crd", longint'(crd), 0);
         chk("rst_cwr", longint'(cwr), 0);
         chk("rst_csel", csel, 0);
         chk("rst_caddr_rd", caddr_rd, 0);
         chk("rst_caddr_wr", caddr_wr, 0);
         chk("rst_cdata_wr", cdata_wr, 0);
      end

      // Ramp run: first window order, first write, busy span.
      reset  = 1'b0;
      edges  = 0;
      rd_idx = 0;
      wr_idx = 0;
      step();
      chk("accept_busy", longint'(busy), 1);
      chk("first_rd0", caddr_rd, 0);
      ready = 1'b0;
      v = '{1, 64, 65};
      for (int k = 0; k < 3; k++) begin
         step();
         chk("first_rd_seq", caddr_rd, v[k]);
      end
      step();
      chk("first_wr_strobe", longint'(cwr), 1);
      chk("first_wr_addr", caddr_wr, 0);
      chk("first_wr_data", cdata_wr, 65);
      wait_done();
      chk("ramp_busy_span", edges, 5121);
      chk("ramp_writes", wr_idx, 1024);
      step();
      chk("idle_after_done", longint'(busy), 0);

      // Signed, tie and last-element windows on a random background; ready chatter while busy.
      for (int a = 0; a < 4096; a++) l0[a] = DW'($urandom);
      l0[0]  = 20'h00005; l0[1]  = 20'hFFFFF; l0[64] = 20'h00003; l0[65] = 20'h80000;
      l0[2]  = 20'h12345; l0[3]  = 20'h12345; l0[66] = 20'h12345; l0[67] = 20'h12345;
      l0[4]  = 20'h00000; l0[5]  = 20'h00000; l0[68] = 20'h00000; l0[69] = 20'h00007;
      build_model();
      chk("model_signed", exp_q[0], 20'h00005);
      chk("model_tie", exp_q[1], 20'h12345);
      chk("model_last", exp_q[2], 20'h00007);
      edges  = 0;
      rd_idx = 0;
      wr_idx = 0;
      ready  = 1'b1;
      step();
      chk("dir_accept_busy", longint'(busy), 1);
      for (int i = 0; i < 200; i++) begin
         ready = 1'($urandom_range(0, 1));
         step();
      end
      ready = 1'b0;
      wait_done();
      chk("dir_busy_span", edges, 5121);
      chk("dir_writes", wr_idx, 1024);
      chk("dir_l1_signed", l1[0], 20'h00005);
      chk("dir_l1_tie", l1[1], 20'h12345);
      chk("dir_l1_last", l1[2], 20'h00007);
      step();

      // Abort during RD2 of output 499 (the 500th).
      fill_ramp();
      rd_idx = 0;
      wr_idx = 0;
      ready  = 1'b1;
      step();
      ready = 1'b0;
      guard = 0;
      while (!(crd && rd_idx == 1999) && guard < 3000) begin
         step();
         guard++;
      end
      chk("abort_reached", longint'(crd && rd_idx == 1999), 1);
      chk("abort_rd2_addr", caddr_rd, 2022);
      reset = 1'b1;
      step();
      chk("abort_busy", longint'(busy), 0);
      chk("abort_crd", longint'(crd), 0);
      chk("abort_cwr", longint'(cwr), 0);
      chk("abort_csel", csel, 0);
      chk("abort_caddr_rd", caddr_rd, 0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("abort_writes", wr_idx, 499);
      chk("abort_stays_idle", longint'(busy), 0);

      // Rerun after abort must produce the complete map.
      edges  = 0;
      rd_idx = 0;
      wr_idx = 0;
      ready  = 1'b1;
      step();
      ready = 1'b0;
      wait_done();
      chk("rerun_busy_span", edges, 5121);
      chk("rerun_writes", wr_idx, 1024);
      for (int i = 0; i < 1024; i++) begin
         chk("rerun_map", l1[i], 128 * (i / 32) + 2 * (i % 32) + 65);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
